// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined FP adder: flag bit positions, operand
// classes, a classifier and the canonical quiet-NaN constructor.
package fp_pkg;
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } fp_class_e;

    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero, input logic frac_msb);
        fp_class_e c;
        if (exp_ones) begin
            c = frac_zero ? CLS_INF : (frac_msb ? CLS_QNAN : CLS_SNAN);
        end else if (exp_zero) begin
            c = frac_zero ? CLS_ZERO : CLS_SUB;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    // Positive sign, all-ones exponent, fraction MSB set, rest zero.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input saturates the count to all ones.
module fp_lzc #(
    parameter int  WIDTH = 14,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    cnt
);
    // Scan upward so the most significant set bit determines the count.
    always_comb begin
        cnt = '1;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = din[i] ? CW'(WIDTH - 1 - i) : cnt;
        end
    end
endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/sub with round-to-nearest-even, subnormals and a
// single global advance shared by all stages.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int  EXP_W = 5,
    parameter int  MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic [4:0]   flags
);
    localparam int XW = MAN_W + 4;
    localparam int CW = $clog2(XW);
    localparam int EW = EXP_W + 1;
    localparam int SW = ((CW > EXP_W) ? CW : EXP_W) + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]    EW_ONE   = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]    SW_ONE   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     QNAN     = W'(canon_qnan(EXP_W, MAN_W));

    logic adv_s;
    assign adv_s    = !out_valid | out_ready;
    assign in_ready = adv_s;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             sa_s, sb_s, a_ge_s, big_sign_s;
    logic [EXP_W-1:0] ea_s, eb_s, eae_s, ebe_s, big_e_s, small_e_s, diff_s;
    logic [MAN_W-1:0] fa_s, fb_s;
    logic [MAN_W:0]   ma_s, mb_s, big_m_s, small_m_s;
    logic [XW-1:0]    small_x_s, aligned_s;
    fp_class_e        cls_a_s, cls_b_s;
    logic             nan_a_s, nan_b_s, inf_a_s, inf_b_s;
    logic             spec_s, spec_nv_s;
    logic [W-1:0]     spec_q_s;

    assign sa_s    = a[W-1];
    assign sb_s    = b[W-1] ^ op;
    assign ea_s    = a[W-2:MAN_W];
    assign eb_s    = b[W-2:MAN_W];
    assign fa_s    = a[MAN_W-1:0];
    assign fb_s    = b[MAN_W-1:0];
    assign cls_a_s = fp_classify(ea_s == '0, ea_s == EXP_ONES, fa_s == '0, fa_s[MAN_W-1]);
    assign cls_b_s = fp_classify(eb_s == '0, eb_s == EXP_ONES, fb_s == '0, fb_s[MAN_W-1]);
    assign nan_a_s = (cls_a_s == CLS_QNAN) || (cls_a_s == CLS_SNAN);
    assign nan_b_s = (cls_b_s == CLS_QNAN) || (cls_b_s == CLS_SNAN);
    assign inf_a_s = (cls_a_s == CLS_INF);
    assign inf_b_s = (cls_b_s == CLS_INF);
    // Subnormals share the minimum normal exponent, hidden bit cleared.
    assign eae_s   = (ea_s == '0) ? EXP_ONE : ea_s;
    assign ebe_s   = (eb_s == '0) ? EXP_ONE : eb_s;
    assign ma_s    = {ea_s != '0, fa_s};
    assign mb_s    = {eb_s != '0, fb_s};
    assign a_ge_s  = (a[W-2:0] >= b[W-2:0]);

    // Special operands override the datapath result.
    always_comb begin
        spec_s    = 1'b0;
        spec_nv_s = 1'b0;
        spec_q_s  = '0;
        if (nan_a_s || nan_b_s) begin
            spec_s    = 1'b1;
            spec_q_s  = QNAN;
            spec_nv_s = (cls_a_s == CLS_SNAN) || (cls_b_s == CLS_SNAN);
        end else if (inf_a_s && inf_b_s && (sa_s != sb_s)) begin
            spec_s    = 1'b1;
            spec_q_s  = QNAN;
            spec_nv_s = 1'b1;
        end else if (inf_a_s) begin
            spec_s   = 1'b1;
            spec_q_s = {sa_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (inf_b_s) begin
            spec_s   = 1'b1;
            spec_q_s = {sb_s, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_s = 1'b0;
        end
    end

    // Larger magnitude first; the smaller one is shifted right keeping G/R/S.
    always_comb begin
        big_e_s    = a_ge_s ? eae_s : ebe_s;
        small_e_s  = a_ge_s ? ebe_s : eae_s;
        big_m_s    = a_ge_s ? ma_s : mb_s;
        small_m_s  = a_ge_s ? mb_s : ma_s;
        big_sign_s = a_ge_s ? sa_s : sb_s;
        diff_s     = big_e_s - small_e_s;
        small_x_s  = {small_m_s, 3'b000};
        if (int'(diff_s) >= XW - 1) begin
            aligned_s = {{(XW-1){1'b0}}, |small_m_s};
        end else begin
            aligned_s = (small_x_s >> diff_s) |
                        {{(XW-1){1'b0}}, |(small_x_s & ~({XW{1'b1}} << diff_s))};
        end
    end

    logic             s1_valid_r, s1_spec_r, s1_nv_r, s1_sign_r, s1_sub_r;
    logic [W-1:0]     s1_spec_q_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic [XW-1:0]    s1_big_r, s1_small_r;

    // S1 register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0; s1_spec_r <= 1'b0; s1_nv_r <= 1'b0;
            s1_sign_r <= 1'b0; s1_sub_r <= 1'b0; s1_spec_q_r <= '0;
            s1_exp_r <= '0; s1_big_r <= '0; s1_small_r <= '0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid; s1_spec_r <= spec_s; s1_nv_r <= spec_nv_s;
            s1_sign_r <= big_sign_s; s1_sub_r <= (sa_s != sb_s); s1_spec_q_r <= spec_q_s;
            s1_exp_r <= big_e_s; s1_big_r <= {big_m_s, 3'b000}; s1_small_r <= aligned_s;
        end
    end

    // ---------------- S2: add/sub magnitudes, leading zeros ----------------
    logic [XW:0]   sum_s;
    logic [CW-1:0] lz_s;

    assign sum_s = s1_sub_r ? ({1'b0, s1_big_r} - {1'b0, s1_small_r})
                            : ({1'b0, s1_big_r} + {1'b0, s1_small_r});

    fp_lzc #(.WIDTH(XW)) u_lzc (.din(sum_s[XW-1:0]), .cnt(lz_s));

    logic             s2_valid_r, s2_spec_r, s2_nv_r, s2_sign_r, s2_sub_r;
    logic [W-1:0]     s2_spec_q_r;
    logic [EXP_W-1:0] s2_exp_r;
    logic [XW:0]      s2_sum_r;
    logic [CW-1:0]    s2_lz_r;

    // S2 register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0; s2_spec_r <= 1'b0; s2_nv_r <= 1'b0;
            s2_sign_r <= 1'b0; s2_sub_r <= 1'b0; s2_spec_q_r <= '0;
            s2_exp_r <= '0; s2_sum_r <= '0; s2_lz_r <= '0;
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r; s2_spec_r <= s1_spec_r; s2_nv_r <= s1_nv_r;
            s2_sign_r <= s1_sign_r; s2_sub_r <= s1_sub_r; s2_spec_q_r <= s1_spec_q_r;
            s2_exp_r <= s1_exp_r; s2_sum_r <= sum_s; s2_lz_r <= lz_s;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [XW-1:0]    norm_s;
    logic [EW-1:0]    exp_n_s, exp_r_s;
    logic [SW-1:0]    lim_s, sh_s;
    logic [MAN_W+1:0] mr_s;
    logic [MAN_W-1:0] frac_s;
    logic             up_s, hidden_s, nx_s, zero_s, ovf_s;
    logic [EXP_W-1:0] exp_f_s;
    logic [W-1:0]     q_s;
    logic [4:0]       flags_s;

    // Left shift is capped so the exponent never drops below 1.
    always_comb begin
        lim_s = {{(SW-EXP_W){1'b0}}, s2_exp_r} - SW_ONE;
        sh_s  = ({{(SW-CW){1'b0}}, s2_lz_r} < lim_s) ? {{(SW-CW){1'b0}}, s2_lz_r} : lim_s;
        if (s2_sum_r[XW]) begin
            norm_s  = {s2_sum_r[XW:2], s2_sum_r[1] | s2_sum_r[0]};
            exp_n_s = {1'b0, s2_exp_r} + EW_ONE;
        end else begin
            norm_s  = s2_sum_r[XW-1:0] << sh_s;
            exp_n_s = EW'({{(SW-EXP_W){1'b0}}, s2_exp_r} - sh_s);
        end
    end

    assign up_s     = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    assign nx_s     = |norm_s[2:0];
    assign mr_s     = {1'b0, norm_s[XW-1:3]} + {{(MAN_W+1){1'b0}}, up_s};
    assign exp_r_s  = mr_s[MAN_W+1] ? (exp_n_s + EW_ONE) : exp_n_s;
    assign frac_s   = mr_s[MAN_W+1] ? mr_s[MAN_W:1] : mr_s[MAN_W-1:0];
    assign hidden_s = mr_s[MAN_W+1] | mr_s[MAN_W];
    assign exp_f_s  = hidden_s ? exp_r_s[EXP_W-1:0] : {EXP_W{1'b0}};
    assign zero_s   = (s2_sum_r == '0);
    assign ovf_s    = hidden_s && (exp_r_s >= {1'b0, EXP_ONES});

    // Result and flag selection.
    always_comb begin
        q_s             = '0;
        flags_s         = 5'b00000;
        flags_s[FLG_DZ] = 1'b0;
        if (s2_spec_r) begin
            q_s             = s2_spec_q_r;
            flags_s[FLG_NV] = s2_nv_r;
        end else if (zero_s) begin
            q_s = {(!s2_sub_r) & s2_sign_r, {(W-1){1'b0}}};
        end else if (ovf_s) begin
            q_s             = {s2_sign_r, EXP_ONES, {MAN_W{1'b0}}};
            flags_s[FLG_OF] = 1'b1;
            flags_s[FLG_NX] = 1'b1;
        end else begin
            q_s             = {s2_sign_r, exp_f_s, frac_s};
            flags_s[FLG_NX] = nx_s;
            flags_s[FLG_UF] = (exp_f_s == '0) & nx_s;
        end
    end

    // Output register; result fields only load on a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            flags     <= 5'b00000;
        end else if (adv_s) begin
            out_valid <= s2_valid_r;
            if (s2_valid_r) begin
                q     <= q_s;
                flags <= flags_s;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench: directed vectors, streaming with stalls, reset flush
// and randomized beats against an exact-integer binary16 reference model.
module tb_fp_addsub_pipe;
    logic        clk, rst_n, in_valid, in_ready, op, out_valid, out_ready;
    logic [15:0] a, b, q;
    logic [4:0]  flags;

    fp_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0, bad = 0, cyc = 0, stall_left = 0;
    logic [20:0] expq[$];
    int          accq[$];
    bit          chk_lat = 1'b1, stall_prev = 1'b0, use_const = 1'b0, acc_flag = 1'b0;
    logic [20:0] const_exp;
    logic [15:0] held_q;
    logic [4:0]  held_f;
    logic [15:0] spc[8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                            16'h7E00, 16'h7D00, 16'h0001, 16'h7BFF};

    // Exact sum in units of the smallest subnormal, then RNE to binary16.
    function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y, input logic sub);
        logic   sx, sy, sg, nx, up;
        int     ex, ey, fx, fy, k, e;
        bit     nanx, nany, snx, sny, infx, infy;
        longint mx, my, s, m, mant, rem, half;
        sx = x[15]; sy = y[15] ^ sub;
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        fx = int'(x[9:0]);   fy = int'(y[9:0]);
        nanx = (ex == 31) && (fx != 0); nany = (ey == 31) && (fy != 0);
        snx = nanx && !x[9]; sny = nany && !y[9];
        infx = (ex == 31) && (fx == 0); infy = (ey == 31) && (fy == 0);
        if (nanx || nany) return {16'h7E00, snx || sny, 4'b0000};
        if (infx && infy && (sx != sy)) return {16'h7E00, 5'b10000};
        if (infx) return {sx, 15'h7C00, 5'b00000};
        if (infy) return {sy, 15'h7C00, 5'b00000};
        mx = (ex == 0) ? longint'(fx) : (longint'(fx + 1024) << (ex - 1));
        my = (ey == 0) ? longint'(fy) : (longint'(fy + 1024) << (ey - 1));
        s = (sx ? -mx : mx) + (sy ? -my : my);
        if (s == 0) return {(sx && sy && mx == 0 && my == 0), 15'h0000, 5'b00000};
        sg = (s < 0);
        m = sg ? -s : s;
        if (m < 2048) return {sg, m[14:0], 5'b00000};
        k = 0;
        while ((m >> k) >= 2048) k++;
        mant = m >> k;
        rem  = m - (mant << k);
        half = 64'sd1 << (k - 1);
        up   = (rem > half) || ((rem == half) && mant[0]);
        mant = mant + longint'(up);
        if (mant == 2048) begin mant = 1024; k++; end
        e  = k + 1;
        nx = (rem != 0);
        if (e >= 31) return {sg, 15'h7C00, 5'b00101};
        return {sg, 5'(e), mant[9:0], 4'b0000, nx};
    endfunction

    task automatic tick();
        logic [20:0] e;
        int          ac;
        @(negedge clk);
        total++;
        assert (in_ready === (!out_valid || out_ready))
            else begin bad++; $error("FAIL in_ready got=%b exp=%b", in_ready, !out_valid || out_ready); end
        if (stall_prev) begin
            total++;
            assert ({q, flags} === {held_q, held_f})
                else begin bad++; $error("FAIL stall_hold got=%h/%b exp=%h/%b", q, flags, held_q, held_f); end
        end
        if (out_valid === 1'b1 && out_ready) begin
            total++;
            assert (expq.size() > 0)
                else begin bad++; $error("FAIL spurious_out got=%h exp=none", q); end
            if (expq.size() > 0) begin
                e  = expq.pop_front();
                ac = accq.pop_front();
                total++;
                assert (q === e[20:5]) else begin bad++; $error("FAIL q got=%h exp=%h", q, e[20:5]); end
                total++;
                assert (flags === e[4:0]) else begin bad++; $error("FAIL flags got=%b exp=%b (q=%h)", flags, e[4:0], e[20:5]); end
                if (chk_lat) begin
                    total++;
                    assert ((cyc - ac) === 3) else begin bad++; $error("FAIL latency got=%0d exp=3", cyc - ac); end
                end
            end
        end
        stall_prev = out_valid && !out_ready;
        held_q = q; held_f = flags;
        acc_flag = in_valid && in_ready;
        if (acc_flag) begin
            expq.push_back(use_const ? const_exp : model(a, b, op));
            accq.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = 1'b1;
    endtask

    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xop,
                        input bit uc, input logic [20:0] ce);
        int n = 0;
        a = xa; b = xb; op = xop; in_valid = 1'b1; use_const = uc; const_exp = ce;
        do begin tick(); n++; end while (!acc_flag && n < 50);
        total++;
        assert (acc_flag) else begin bad++; $error("FAIL accept_timeout got=0 exp=1"); end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && expq.size() > 0; i++) tick();
        tick();
        total++;
        assert (expq.size() == 0) else begin bad++; $error("FAIL drain got=%0d exp=0", expq.size()); end
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       return spc[$urandom_range(0, 7)];
            1:       return 16'($urandom_range(0, 16'h07FF)) | (16'($urandom_range(0, 1)) << 15);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; assert (out_valid === 1'b0) else begin bad++; $error("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; assert (q === 16'h0000) else begin bad++; $error("FAIL rst_q got=%h exp=0000", q); end
        total++; assert (flags === 5'b00000) else begin bad++; $error("FAIL rst_flags got=%b exp=00000", flags); end
        total++; assert (in_ready === 1'b1) else begin bad++; $error("FAIL rst_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;

        // Directed vectors with hand-derived results, one beat at a time.
        send(16'h3C00, 16'h3800, 1'b0, 1'b1, {16'h3E00, 5'b00000}); drain();
        send(16'h3C00, 16'h3800, 1'b1, 1'b1, {16'h3800, 5'b00000}); drain();
        send(16'h3C00, 16'h3C00, 1'b1, 1'b1, {16'h0000, 5'b00000}); drain();
        send(16'h8000, 16'h8000, 1'b0, 1'b1, {16'h8000, 5'b00000}); drain();
        send(16'h7C00, 16'h7C00, 1'b1, 1'b1, {16'h7E00, 5'b10000}); drain();
        send(16'h7D00, 16'h3C00, 1'b0, 1'b1, {16'h7E00, 5'b10000}); drain();
        send(16'h7BFF, 16'h7BFF, 1'b0, 1'b1, {16'h7C00, 5'b00101}); drain();
        send(16'h0001, 16'h0001, 1'b0, 1'b1, {16'h0002, 5'b00000}); drain();
        send(16'h3C00, 16'h0001, 1'b0, 1'b1, {16'h3C00, 5'b00001}); drain();
        send(16'h7C00, 16'hBC00, 1'b0, 1'b1, {16'h7C00, 5'b00000}); drain();
        send(16'h3C01, 16'h3C00, 1'b1, 1'b1, {16'h1400, 5'b00000}); drain();
        send(16'h0400, 16'h0001, 1'b1, 1'b1, {16'h03FF, 5'b00000}); drain();

        // Back-to-back stream with a 4-cycle downstream stall.
        chk_lat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) stall_left = 4;
            send(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b0, 21'h0);
        end
        drain();

        // Reset with three beats in flight.
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) send(16'h3C00, 16'h4000, 1'b0, 1'b0, 21'h0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; assert (out_valid === 1'b0) else begin bad++; $error("FAIL midrst_valid got=%b exp=0", out_valid); end
        total++; assert (q === 16'h0000) else begin bad++; $error("FAIL midrst_q got=%h exp=0000", q); end
        total++; assert (flags === 5'b00000) else begin bad++; $error("FAIL midrst_flags got=%b exp=00000", flags); end
        expq.delete(); accq.delete(); stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        send(16'h4000, 16'h3C00, 1'b1, 1'b1, {16'h3C00, 5'b00000}); drain();

        // Randomized beats with random stalls and gaps.
        chk_lat = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ra = rnd_val();
            rb = ($urandom_range(0, 3) == 0) ? (ra ^ 16'($urandom_range(0, 31))) : rnd_val();
            if ($urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 3);
            send(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 21'h0);
            if ($urandom_range(0, 5) == 0) begin in_valid = 1'b0; tick(); end
        end
        drain();

        // Randomized full-rate stream, latency checked on every beat.
        chk_lat = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ra = rnd_val();
            rb = ($urandom_range(0, 2) == 0) ? (ra ^ 16'($urandom_range(0, 7))) : rnd_val();
            send(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 21'h0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor; the successor to the combinational half-precision subtract datapath. Exponent and mantissa widths are parameters (default binary16). Adds a run-time add/sub select, round-to-nearest-even with full subnormal support, and a 3-stage valid/ready pipeline with backpressure. Sits between the operand decode stage and result writeback in the FP unit.

## Interface
- EXP_W, 5, exponent field width (≥3)
- MAN_W, 10, stored fraction width (≥2); total width W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- op  in  1  0 = a+b, 1 = a−b
- a, b  in  W  packed operands {sign, exp, frac}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- q  out  W  packed result
- flags  out  5  {invalid, divzero, overflow, underflow, inexact}; divzero always 0

## Operation
- b's sign is inverted when op=1; all following rules apply to effective add of a and b'.
- Classification: zero, subnormal, normal, inf, qNaN, sNaN (sNaN = exp all ones, frac MSB 0, frac≠0).
- Special cases (override datapath):
  - any NaN operand → canonical qNaN {0, all-ones, 1, 0…}; invalid=1 only if an operand is sNaN.
  - inf + (−inf) → canonical qNaN, invalid=1.
  - inf ± finite, or same-signed infs → that inf, flags 0.
- Finite path: hidden bit = 1 for normals, 0 for subnormals (subnormal effective exp = 1). Swap so |a| ≥ |b'|; align smaller by exponent difference with guard, round and sticky bits (difference ≥ MAN_W+3 collapses to sticky only).
- Add or subtract magnitudes by sign equality; result sign = sign of larger magnitude.
- Normalise: right shift by 1 on carry-out, else left shift by leading-zero count, limited so exponent does not go below 1 (subnormal output).
- Round-to-nearest-even on guard/round/sticky; rounding carry renormalises.
- Exact zero result: +0, except (−0)+(−0) → −0.
- Overflow: rounded exponent ≥ all-ones → ±inf, overflow=1, inexact=1.
- inexact = any discarded bit nonzero. underflow = result subnormal or zero (after rounding) AND inexact.

## Timing
- Latency exactly 3 cycles from accepted beat to out_valid with no stall; throughput 1 beat/cycle.
- Stage regs S1 (unpack/classify/swap/align), S2 (add/sub, leading-zero count), S3 (normalise/round/pack = output register).
- Pipeline advances when adv = !out_valid | out_ready; all stages stall together. in_ready = adv (combinational from out_ready and out_valid only).
- Bubbles propagate as valid=0; pipeline collapses bubbles only through the global advance (no per-stage skid).
- While out_valid=1 and out_ready=0: q, flags held stable.
- Accept = in_valid & in_ready; out transfer = out_valid & out_ready; both may occur in the same cycle.
- Reset: all stage valid bits 0, out_valid=0, q=0, flags=0; in_ready=1 after reset. Reset mid-operation discards in-flight beats; no partial result emitted.

## Structure
- Package fp_pkg: flag bit index constants (FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0), operand-class enum, canonical-qNaN constructor function parametrised by EXP_W/MAN_W.
- Sub-module fp_lzc: parametrised leading-zero counter used in S2, width MAN_W+4, count output $clog2 of that width.

## Test plan
- Defaults, out_ready=1: a=0x3C00, b=0x3800, op=0 → after 3 cycles q=0x3E00, flags=00000; op=1 → q=0x3800.
- a=0x3C00, b=0x3C00, op=1 → q=0x0000; a=0x8000, b=0x8000, op=0 → q=0x8000; flags 00000.
- a=0x7C00, b=0x7C00, op=1 → q=0x7E00, flags=10000; a=0x7D00 (sNaN), b=0x3C00 → q=0x7E00, flags=10000.
- a=0x7BFF, b=0x7BFF, op=0 → q=0x7C00, flags=00101; a=0x0001, b=0x0001 → q=0x0002, flags 00000; a=0x3C00, b=0x0001 → q=0x3C00, flags=00001.
- Stream 8 back-to-back beats, hold out_ready=0 for 4 cycles mid-stream → in_ready low exactly while out_valid&!out_ready, no beat lost/duplicated, results in order, q stable while stalled.
- Assert rst_n low with 3 beats in flight → out_valid=0, q=0, flags=0 immediately; after release, first new beat emerges 3 cycles after acceptance with correct value.
